bft_stream_packetizer: RTL and testbench



---
 rtl/bft_stream_packetizer.sv | 144 ++++++++++++++
 tb/tb_bft_stream_packetizer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bft_stream_packetizer.sv
// bft_stream_packetizer
// Host-side transmitter toward a BFT leaf. Wraps each 32-bit stream word in a
// 49-bit BFT packet addressed to one port of a destination leaf, and tracks
// free space in the receiver's BRAM ring as credits so the ring never overruns.
// Freespace-update packets returning from the leaf add credits.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ap_start                   start a transfer (level, sampled in IDLE)
//   cfg_dst_leaf/port/num_words transfer configuration, latched at start
//   s_tdata/s_tvalid/s_tready  input AXI-stream
//   din_leaf_bft2interface     packets from the BFT (credit returns)
//   dout_leaf_interface2bft    packets to the BFT, one per cycle, 0 when idle
//   credit                     current credit count
//   ap_done                    one-cycle done pulse
module bft_stream_packetizer #(
  parameter int unsigned PACKET_BITS        = 49,
  parameter int unsigned PAYLOAD_BITS       = 32,
  parameter int unsigned NUM_LEAF_BITS      = 5,
  parameter int unsigned NUM_PORT_BITS      = 4,
  parameter int unsigned NUM_BRAM_ADDR_BITS = 7,
  parameter int unsigned CREDIT_PORT        = 0,
  parameter int unsigned CNT_BITS           = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [NUM_LEAF_BITS-1:0]      cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]      cfg_dst_port,
  input  logic [CNT_BITS-1:0]           cfg_num_words,
  input  logic [PAYLOAD_BITS-1:0]       s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
  output logic [NUM_BRAM_ADDR_BITS:0]   credit,
  output logic                          ap_done
);

  localparam int unsigned CreditBits = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned SumBits    = CreditBits + 1;
  localparam int unsigned MaxCredit  = 1 << NUM_BRAM_ADDR_BITS;
  localparam int unsigned AmtBits    = 8;
  localparam int unsigned LeafHi     = PACKET_BITS - 2;
  localparam int unsigned PortHi     = LeafHi - NUM_LEAF_BITS;
  localparam int unsigned AddrHi     = PortHi - NUM_PORT_BITS;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                    r_state;
  logic [NUM_LEAF_BITS-1:0]      r_leaf;
  logic [NUM_PORT_BITS-1:0]      r_port;
  logic [CNT_BITS-1:0]           r_remaining;
  logic [NUM_BRAM_ADDR_BITS-1:0] r_wr_addr;
  logic [CreditBits-1:0]         r_credit;
  logic [PACKET_BITS-1:0]        r_dout;
  logic                          r_ap_done;

  logic                          w_handshake;
  logic [NUM_LEAF_BITS-1:0]      w_match_leaf;
  logic                          w_credit_upd;
  logic [AmtBits-1:0]            w_amount;
  logic [SumBits-1:0]            w_credit_sum;
  logic [CreditBits-1:0]         w_credit_nxt;
  logic                          w_unused_din;

  assign s_tready    = (r_state == StRun) && (r_credit != '0) && (r_remaining != '0);
  assign w_handshake = s_tvalid && s_tready;

  // In IDLE nothing is latched yet, so credit returns are matched against the
  // live configuration instead.
  assign w_match_leaf = (r_state == StIdle) ? cfg_dst_leaf : r_leaf;
  assign w_credit_upd = din_leaf_bft2interface[PACKET_BITS-1] &&
                        (din_leaf_bft2interface[LeafHi -: NUM_LEAF_BITS] == w_match_leaf) &&
                        (din_leaf_bft2interface[PortHi -: NUM_PORT_BITS] ==
                         NUM_PORT_BITS'(CREDIT_PORT));
  assign w_amount     = w_credit_upd ? din_leaf_bft2interface[AmtBits-1:0] : '0;

  // One bit wider than the credit so credit+amount cannot wrap before the
  // clamp; consume only happens with credit!=0, so no underflow either.
  always_comb begin
    w_credit_sum = SumBits'(r_credit) + SumBits'(w_amount) - SumBits'(w_handshake);
    w_credit_nxt = w_credit_sum[CreditBits-1:0];
    if (w_credit_sum > SumBits'(MaxCredit)) begin
      w_credit_nxt = CreditBits'(MaxCredit);
    end
  end

  assign w_unused_din = ^din_leaf_bft2interface[AddrHi:AmtBits];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_leaf      <= '0;
      r_port      <= '0;
      r_remaining <= '0;
      r_wr_addr   <= '0;
      r_credit    <= CreditBits'(MaxCredit);
      r_dout      <= '0;
      r_ap_done   <= 1'b0;
    end else begin
      r_credit  <= w_credit_nxt;
      r_ap_done <= (r_state == StDone);
      r_dout    <= '0;
      if (w_handshake) begin
        r_dout      <= {1'b1, r_leaf, r_port, r_wr_addr, s_tdata};
        r_wr_addr   <= r_wr_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (ap_start) begin
            if (cfg_num_words != '0) begin
              r_leaf      <= cfg_dst_leaf;
              r_port      <= cfg_dst_port;
              r_remaining <= cfg_num_words;
              r_state     <= StRun;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StRun: begin
          if (w_handshake && (r_remaining == CNT_BITS'(1))) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign dout_leaf_interface2bft = r_dout;
  assign credit                  = r_credit;
  assign ap_done                 = r_ap_done;

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Directed self-checking bench for bft_stream_packetizer.
module tb_bft_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic [4:0]  cfg_dst_leaf = '0;
  logic [3:0]  cfg_dst_port = '0;
  logic [15:0] cfg_num_words = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [48:0] din = '0;
  logic [48:0] dout;
  logic [7:0]  credit;
  logic        ap_done;

  int total = 0;
  int bad = 0;

  bft_stream_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .ap_start                (ap_start),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .cfg_num_words           (cfg_num_words),
    .s_tdata                 (s_tdata),
    .s_tvalid                (s_tvalid),
    .s_tready                (s_tready),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .credit                  (credit),
    .ap_done                 (ap_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [48:0] pkt(input logic [4:0] l, input logic [3:0] p,
                                      input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  function automatic logic [48:0] cpkt(input logic [4:0] l, input logic [3:0] p,
                                       input logic [7:0] amt);
    return {1'b1, l, p, 7'd0, 24'd0, amt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = 1'b0;
    din = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [4:0] l, input logic [3:0] p, input logic [15:0] n);
    cfg_dst_leaf = l;
    cfg_dst_port = p;
    cfg_num_words = n;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  // Streams n words base+i; each packet must appear one cycle after its handshake.
  task automatic send(input int n, input logic [31:0] base, input logic [6:0] a0,
                      input logic [4:0] l, input logic [3:0] p);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      s_tvalid = 1'b1;
      s_tdata = base + i;
      while (!s_tready && w < 20) begin
        tick();
        w++;
      end
      chk("tready", {63'd0, s_tready}, 64'd1);
      tick();
      chk("pkt", {15'd0, dout}, {15'd0, pkt(l, p, a0 + 7'(i), base + i)});
    end
    s_tvalid = 1'b0;
  endtask

  // Called right after the last packet edge: FSM is in DONE, pulse follows.
  task automatic finish_check();
    tick();
    chk("ap_done_hi", {63'd0, ap_done}, 64'd1);
    chk("dout_idle", {15'd0, dout}, 64'd0);
    tick();
    chk("ap_done_lo", {63'd0, ap_done}, 64'd0);
  endtask

  initial begin
    logic [48:0] tmp;

    // Reset state
    tick();
    chk("rst_dout", {15'd0, dout}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_done", {63'd0, ap_done}, 64'd0);
    chk("rst_credit", {56'd0, credit}, 64'd128);
    reset = 1'b0;
    tick();

    // Basic: 4 words to leaf 3 port 2, addresses 0..3
    start(5'd3, 4'd2, 16'd4);
    chk("basic_dout0", {15'd0, dout}, 64'd0);
    send(4, 32'hA0, 7'd0, 5'd3, 4'd2);
    chk("basic_credit", {56'd0, credit}, 64'd124);
    finish_check();

    // Zero-length: done pulse two cycles after start, no packet, wr_addr kept
    start(5'd3, 4'd2, 16'd0);
    chk("zero_done0", {63'd0, ap_done}, 64'd0);
    chk("zero_tready", {63'd0, s_tready}, 64'd0);
    tick();
    chk("zero_done1", {63'd0, ap_done}, 64'd1);
    chk("zero_dout", {15'd0, dout}, 64'd0);
    tick();
    chk("zero_done2", {63'd0, ap_done}, 64'd0);
    start(5'd3, 4'd2, 16'd1);
    send(1, 32'h55, 7'd4, 5'd3, 4'd2);
    chk("zero_credit", {56'd0, credit}, 64'd123);
    finish_check();

    // Credit exhaustion and ring wrap
    do_reset();
    start(5'd3, 4'd2, 16'd130);
    send(128, 32'h1000, 7'd0, 5'd3, 4'd2);
    chk("exh_credit0", {56'd0, credit}, 64'd0);
    chk("exh_tready0", {63'd0, s_tready}, 64'd0);
    s_tvalid = 1'b1;
    s_tdata = 32'h1080;
    tick();
    chk("exh_stall_dout", {15'd0, dout}, 64'd0);
    chk("exh_stall_tready", {63'd0, s_tready}, 64'd0);
    din = cpkt(5'd3, 4'd0, 8'd64);
    tick();
    din = '0;
    chk("exh_credit64", {56'd0, credit}, 64'd64);
    chk("exh_tready1", {63'd0, s_tready}, 64'd1);
    send(2, 32'h1080, 7'd0, 5'd3, 4'd2);
    chk("exh_credit62", {56'd0, credit}, 64'd62);
    finish_check();

    // Simultaneous consume and update: 10 - 1 + 5
    do_reset();
    start(5'd3, 4'd2, 16'd119);
    send(118, 32'h2000, 7'd0, 5'd3, 4'd2);
    chk("sim_credit10", {56'd0, credit}, 64'd10);
    s_tvalid = 1'b1;
    s_tdata = 32'hBEEF;
    din = cpkt(5'd3, 4'd0, 8'd5);
    chk("sim_tready", {63'd0, s_tready}, 64'd1);
    tick();
    din = '0;
    s_tvalid = 1'b0;
    chk("sim_credit14", {56'd0, credit}, 64'd14);
    chk("sim_pkt", {15'd0, dout}, {15'd0, pkt(5'd3, 4'd2, 7'd118, 32'hBEEF)});
    finish_check();

    // Saturation and filtering in IDLE
    do_reset();
    start(5'd3, 4'd2, 16'd8);
    send(8, 32'h300, 7'd0, 5'd3, 4'd2);
    finish_check();
    chk("sat_credit120", {56'd0, credit}, 64'd120);
    din = cpkt(5'd4, 4'd0, 8'd64);
    tick();
    chk("flt_leaf", {56'd0, credit}, 64'd120);
    din = cpkt(5'd3, 4'd1, 8'd64);
    tick();
    chk("flt_port", {56'd0, credit}, 64'd120);
    tmp = cpkt(5'd3, 4'd0, 8'd64);
    tmp[48] = 1'b0;
    din = tmp;
    tick();
    chk("flt_valid", {56'd0, credit}, 64'd120);
    din = cpkt(5'd3, 4'd0, 8'd64);
    tick();
    din = '0;
    chk("sat_credit128", {56'd0, credit}, 64'd128);

    // Asynchronous reset mid-transfer (wr_addr is 8 here)
    start(5'd3, 4'd2, 16'd20);
    send(5, 32'h400, 7'd8, 5'd3, 4'd2);
    s_tvalid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_dout", {15'd0, dout}, 64'd0);
    chk("arst_tready", {63'd0, s_tready}, 64'd0);
    chk("arst_credit", {56'd0, credit}, 64'd128);
    tick();
    reset = 1'b0;
    s_tvalid = 1'b0;
    start(5'd3, 4'd2, 16'd1);
    send(1, 32'h77, 7'd0, 5'd3, 4'd2);
    finish_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
